// File: rtl/uart_out_arbiter_pkg.sv
// Shared constants for the UART outgoing-message path: message width,
// source indices and the output arbiter FSM encoding.
package uart_out_arbiter_pkg;

  localparam int UART_MSG_WIDTH = 32;

  localparam int SRC_CONTROLLER  = 0;
  localparam int SRC_MEM_MANAGER = 1;
  localparam int SRC_DIAG        = 2;

  typedef enum logic {
    ARB = 1'b0,
    ACK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ. Reusable for any shared resource.
module uart_out_arbiter_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  localparam logic [PTR_W:0] NREQ = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0] idx;
  logic           found;

  assign gnt_vld = |req;

  always_comb begin
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr + k never exceeds 2*NUM_REQ-2, so one subtraction wraps it
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx[PTR_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_out_arbiter.sv
// Round-robin arbiter for the outgoing UART message FIFO write port.
// One whole message per grant, never writes while full, sticky stall error.
module uart_out_arbiter
  import uart_out_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int MSG_WIDTH   = UART_MSG_WIDTH,
  parameter int STALL_LIMIT = 1_000_000
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*MSG_WIDTH-1:0] req_msg,
  output logic [NUM_REQ-1:0]           req_ack,
  input  logic                         fifo_full,
  output logic [MSG_WIDTH-1:0]         fifo_msg,
  output logic                         fifo_wr_en,
  output logic                         stall_err,
  input  logic                         stall_clr
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STALL_LIMIT);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [MSG_WIDTH-1:0] fifo_msg_q, fifo_msg_d;
  logic                 fifo_wr_en_q, fifo_wr_en_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic                 stall_err_q, stall_err_d;

  logic [PTR_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic [MSG_WIDTH-1:0] msg_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_msg
    assign msg_arr[i] = req_msg[i*MSG_WIDTH +: MSG_WIDTH];
  end

  uart_out_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    stall_cnt_d  = stall_cnt_q;
    fifo_msg_d   = fifo_msg_q;
    fifo_wr_en_d = 1'b0;
    req_ack_d    = '0;
    unique case (state_q)
      ARB: begin
        if (gnt_vld && !fifo_full) begin
          fifo_msg_d         = msg_arr[gnt_idx];
          fifo_wr_en_d       = 1'b1;
          req_ack_d[gnt_idx] = 1'b1;
          rr_ptr_d           = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
          stall_cnt_d        = '0;
          state_d            = ACK;
        end else if (!gnt_vld) begin
          stall_cnt_d = '0;
        end else if (stall_cnt_q != LIMIT) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end
      // Lets sources drop/replace valid and fifo_full catch up with the write
      ACK: state_d = ARB;
      default: state_d = ARB;
    endcase

    stall_err_d = stall_err_q;
    if (stall_clr)                stall_err_d = 1'b0;
    else if (stall_cnt_d == LIMIT) stall_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ARB;
      rr_ptr_q     <= '0;
      stall_cnt_q  <= '0;
      fifo_msg_q   <= '0;
      fifo_wr_en_q <= 1'b0;
      req_ack_q    <= '0;
      stall_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      stall_cnt_q  <= stall_cnt_d;
      fifo_msg_q   <= fifo_msg_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      req_ack_q    <= req_ack_d;
      stall_err_q  <= stall_err_d;
    end
  end

  assign fifo_msg   = fifo_msg_q;
  assign fifo_wr_en = fifo_wr_en_q;
  assign req_ack    = req_ack_q;
  assign stall_err  = stall_err_q;

endmodule

// File: tb/tb_uart_out_arbiter.sv
// Directed bench for uart_out_arbiter: 3-source instance with STALL_LIMIT=8
// plus a 5-source instance for pointer wrap.
module tb_uart_out_arbiter;

  localparam int MW = 32;

  logic          clk = 1'b0;
  logic          n_reset;
  logic [2:0]    req_valid;
  logic [3*MW-1:0] req_msg;
  logic [2:0]    req_ack;
  logic          fifo_full;
  logic [MW-1:0] fifo_msg;
  logic          fifo_wr_en;
  logic          stall_err;
  logic          stall_clr;

  logic [4:0]    v5;
  logic [5*MW-1:0] m5;
  logic [4:0]    ack5;
  logic          full5;
  logic [MW-1:0] msg5;
  logic          wr5;
  logic          err5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_out_arbiter #(.NUM_REQ(3), .MSG_WIDTH(MW), .STALL_LIMIT(8)) dut (
    .clk(clk), .n_reset(n_reset), .req_valid(req_valid), .req_msg(req_msg),
    .req_ack(req_ack), .fifo_full(fifo_full), .fifo_msg(fifo_msg),
    .fifo_wr_en(fifo_wr_en), .stall_err(stall_err), .stall_clr(stall_clr)
  );

  uart_out_arbiter #(.NUM_REQ(5), .MSG_WIDTH(MW), .STALL_LIMIT(8)) dut5 (
    .clk(clk), .n_reset(n_reset), .req_valid(v5), .req_msg(m5),
    .req_ack(ack5), .fifo_full(full5), .fifo_msg(msg5),
    .fifo_wr_en(wr5), .stall_err(err5), .stall_clr(stall_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] fmsg(input int src, input int gen);
    return 32'h1000_0000 | MW'(src << 8) | MW'(gen);
  endfunction

  initial begin
    int gen [3];
    int nw;
    int bad;
    int exp_src;

    n_reset = 1'b0; req_valid = '0; req_msg = '0; fifo_full = 1'b0; stall_clr = 1'b0;
    v5 = '0; m5 = '0; full5 = 1'b0;
    #12;
    chk("rst_wr", fifo_wr_en, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_msg", fifo_msg, 0);
    chk("rst_err", stall_err, 0);
    n_reset = 1'b1;

    // single request from source 1
    req_valid = 3'b010;
    req_msg[1*MW +: MW] = 32'hA5A5_0001;
    tick();
    chk("single_wr", fifo_wr_en, 1);
    chk("single_msg", fifo_msg, 32'hA5A5_0001);
    chk("single_ack", req_ack, 3'b010);
    chk("single_ptr", dut.rr_ptr_q, 2);
    req_valid = '0;
    tick();
    chk("single_wr_lo", fifo_wr_en, 0);
    chk("single_ack_lo", req_ack, 0);
    chk("single_msg_hold", fifo_msg, 32'hA5A5_0001);

    // fairness from rr_ptr=0, every source reloads on ack
    n_reset = 1'b0; #1; n_reset = 1'b1;
    for (int s = 0; s < 3; s++) begin
      gen[s] = 0;
      req_msg[s*MW +: MW] = fmsg(s, 0);
    end
    req_valid = 3'b111;
    nw = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("fair_alt", fifo_wr_en, (i % 2 == 0) ? 1 : 0);
      if (fifo_wr_en) begin
        exp_src = nw % 3;
        chk("fair_ack", req_ack, 64'(1) << exp_src);
        chk("fair_msg", fifo_msg, fmsg(exp_src, gen[exp_src]));
        gen[exp_src]++;
        req_msg[exp_src*MW +: MW] = fmsg(exp_src, gen[exp_src]);
        nw++;
      end
    end
    chk("fair_cnt", nw, 6);
    req_valid = '0;

    // backpressure: 20 cycles full, then one write
    fifo_full = 1'b1;
    req_valid = 3'b001;
    req_msg[0 +: MW] = 32'hBEEF_0000;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fifo_wr_en !== 1'b0 || req_ack !== 3'b000) bad++;
    end
    chk("bp_blocked", bad, 0);
    fifo_full = 1'b0;
    tick();
    chk("bp_wr", fifo_wr_en, 1);
    chk("bp_ack", req_ack, 3'b001);
    chk("bp_msg", fifo_msg, 32'hBEEF_0000);
    req_valid = '0;
    nw = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (fifo_wr_en) nw++;
    end
    chk("bp_single", nw, 0);
    chk("bp_err", stall_err, 1);

    // stall error with STALL_LIMIT=8
    stall_clr = 1'b1; tick(); stall_clr = 1'b0;
    chk("st_clr0", stall_err, 0);
    fifo_full = 1'b1;
    req_valid = 3'b001;
    repeat (7) tick();
    chk("st_before", stall_err, 0);
    tick();
    chk("st_set", stall_err, 1);
    stall_clr = 1'b1; tick(); stall_clr = 1'b0;
    chk("st_clr_low", stall_err, 0);
    tick();
    chk("st_reset_again", stall_err, 1);
    fifo_full = 1'b0;
    tick();
    chk("st_grant", fifo_wr_en, 1);
    req_valid = '0;
    tick();
    chk("st_sticky", stall_err, 1);
    stall_clr = 1'b1; tick(); stall_clr = 1'b0;
    chk("st_clr1", stall_err, 0);
    fifo_full = 1'b1;
    req_valid = 3'b001;
    repeat (7) tick();
    chk("st2_before", stall_err, 0);
    tick();
    chk("st2_set", stall_err, 1);
    req_valid = '0; fifo_full = 1'b0;
    stall_clr = 1'b1; tick(); stall_clr = 1'b0;

    // reset during the ACK cycle
    req_valid = 3'b100;
    req_msg[2*MW +: MW] = 32'hCAFE_0002;
    tick();
    chk("mid_wr", fifo_wr_en, 1);
    chk("mid_ack", req_ack, 3'b100);
    n_reset = 1'b0;
    #1;
    chk("mid_rst_wr", fifo_wr_en, 0);
    chk("mid_rst_ack", req_ack, 0);
    chk("mid_rst_msg", fifo_msg, 0);
    chk("mid_rst_ptr", dut.rr_ptr_q, 0);
    n_reset = 1'b1;
    tick();
    chk("mid_re_wr", fifo_wr_en, 1);
    chk("mid_re_ack", req_ack, 3'b100);
    chk("mid_re_msg", fifo_msg, 32'hCAFE_0002);
    req_valid = '0;
    nw = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (fifo_wr_en) nw++;
    end
    chk("mid_single", nw, 0);

    // NUM_REQ=5 pointer wrap
    v5 = 5'b01000;
    m5[3*MW +: MW] = 32'h5555_0003;
    tick();
    chk("w5_ack3", ack5, 5'b01000);
    chk("w5_ptr4", dut5.rr_ptr_q, 4);
    v5 = '0;
    tick();
    v5 = 5'b10001;
    m5[4*MW +: MW] = 32'h5555_0004;
    m5[0 +: MW]    = 32'h5555_0000;
    tick();
    chk("w5_ack4", ack5, 5'b10000);
    chk("w5_msg4", msg5, 32'h5555_0004);
    chk("w5_ptr0", dut5.rr_ptr_q, 0);
    v5 = 5'b00001;
    tick();
    chk("w5_gap", wr5, 0);
    tick();
    chk("w5_ack0", ack5, 5'b00001);
    chk("w5_msg0", msg5, 32'h5555_0000);
    chk("w5_ptr1", dut5.rr_ptr_q, 1);
    v5 = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_out_arbiter.md
# uart_out_arbiter

Round-robin arbiter that shares the single write port of the outgoing message FIFO, which feeds the message disassembler and UART TX, between several message sources. Sources are the controller, memory-manager status reporting and future diagnostic sources. It grants one whole message per transaction and never writes while the FIFO reports full. It also flags a sticky error when sources are blocked by a full FIFO for too long.

## Interface
Parameters:
- NUM_REQ, 3, number of requesting sources (2..8)
- MSG_WIDTH, UART_MSG_WIDTH, message width in bits
- STALL_LIMIT, 1_000_000, cycles of blocked request before stall_err sets (≥1)

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-source "message pending"; held until acked
- req_msg  in  NUM_REQ*MSG_WIDTH  source i occupies bits [i*MSG_WIDTH +: MSG_WIDTH]; stable while valid
- req_ack  out  NUM_REQ  one-cycle pulse, one-hot, message i consumed
- fifo_full  in  1  full flag of outgoing FIFO
- fifo_msg  out  MSG_WIDTH  data to FIFO data_in
- fifo_wr_en  out  1  one-cycle write strobe to FIFO wr_en
- stall_err  out  1  sticky: requests blocked ≥ STALL_LIMIT consecutive cycles
- stall_clr  in  1  synchronous clear of stall_err

## Operation
- Two-state FSM: ARB, ACK. Reset state ARB.
- ARB:
  - If fifo_full=0 and any req_valid, pick g = first set bit of req_valid searching upward from rr_ptr, wrapping.
  - Register fifo_msg<=req_msg[g], fifo_wr_en<=1, req_ack<=one-hot(g), rr_ptr<=(g+1) mod NUM_REQ. Go to ACK.
  - Otherwise fifo_wr_en=0, req_ack=0, stay in ARB.
- ACK: fifo_wr_en<=0 and req_ack<=0 at the next edge; no arbitration this cycle. Return to ARB.
- Rationale for ACK: sources see ack and drop or replace valid, and fifo_full reflects the write, before the next arbitration.
- rr_ptr: $clog2(NUM_REQ) bits, reset 0, advances only on grant. Wrap is explicit modulo NUM_REQ, which need not be a power of 2.
- Source protocol: valid may rise any cycle. Msg and valid are held until the ack cycle. Valid may stay high in the cycle after ack only if it presents a new message.
- Stall counter:
  - Counts cycles with (|req_valid && fifo_full) in ARB.
  - Resets to 0 on any grant or when no request is pending.
  - Saturates at STALL_LIMIT.
  - Reaching STALL_LIMIT sets stall_err.
- stall_err: cleared by stall_clr. If clear and set occur in the same cycle, clear wins. The counter keeps running.
- fifo_msg holds its last granted value when not writing; only fifo_wr_en qualifies it.

## Timing
- Reset values: req_ack=0, fifo_wr_en=0, fifo_msg=0, stall_err=0, state=ARB, rr_ptr=0, stall counter=0.
- Reset mid-transaction aborts immediately. An unacked message is not written. A strobe in flight is deasserted asynchronously.
- Latency: req_valid high in cycle N with fifo_full=0 and FSM in ARB → fifo_wr_en and req_ack[g] high in cycle N+1.
- Throughput: max one message per 2 cycles.
- fifo_full is sampled only in ARB. Full rising in the ACK cycle has no effect on the write already issued. The FIFO must accept a write in the cycle after it reported not-full.
- A request arriving in the ACK cycle waits for the next ARB cycle, with no loss.
- Simultaneous requests are resolved purely by rr_ptr. Each source waits at most NUM_REQ-1 grants.
- stall_err rises the cycle after the counter reaches STALL_LIMIT.

## Structure
- Shared package/header, alongside the UART message constants: UART_MSG_WIDTH, source index constants (SRC_CONTROLLER=0, SRC_MEM_MANAGER=1, SRC_DIAG=2), FSM state encodings.
- One sub-module, rr_pick: combinational, takes req vector and pointer, returns grant index plus any-valid. Reusable for other shared resources.
- No RAM; all state is registers.

## Test plan
- Single request: req_valid=3'b010, msg 0xA5A5_0001, full=0 → cycle N+1: fifo_wr_en=1, fifo_msg=0xA5A5_0001, req_ack=3'b010; both low at N+2; rr_ptr=2.
- Fairness: all three valid continuously, each source reloading a new message on ack → grant order 0,1,2,0,1,2. Writes every other cycle, exactly 6 writes in 12 cycles.
- Full backpressure: fifo_full=1 for 20 cycles with req_valid=3'b001 → no wr_en, no ack. Full falls → grant on the next ARB cycle; exactly one write.
- Stall error: STALL_LIMIT=8, full held with a pending request → stall_err=1 on the 9th cycle. stall_clr pulse while still blocked → stall_err=0 for one cycle, then it sets again. After a grant and a fresh 8-cycle block it sets again.
- Reset mid-op: assert n_reset low in the ACK cycle → wr_en and ack drop immediately. After release, rr_ptr=0 and an identical request produces a single write.
- NUM_REQ=5 wrap: rr_ptr=4, requests 3'b…10001 → grant 4 then 0, pointer goes 0 then 1.
